// File: rtl/sensor_dwell_qualifier.sv
// Per-channel sensor dwell qualifier: a synchronised sensor must stay active for act_len
// cycles and then idle for idle_len cycles before the sticky passed flag is raised.
module sensor_dwell_qualifier #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] act_len,
  input  logic [CNT_W-1:0] idle_len,
  input  logic [N_CH-1:0]  sens_active,
  input  logic [N_CH-1:0]  clr,
  output logic [N_CH-1:0]  passed,
  output logic [N_CH-1:0]  pass_pulse,
  output logic [N_CH-1:0]  abort_pulse,
  output logic [N_CH-1:0]  busy,
  output logic             any_passed
);

  // Interface contract: no valid/ready handshakes; passed and busy are levels decoded from
  // registered state, pass_pulse/abort_pulse are registered single-cycle strobes.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  s;
  logic [CNT_W-1:0] act_eff;
  logic [CNT_W-1:0] idle_eff;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= sens_active;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign act_eff  = (act_len  == '0) ? CNT_W'(1) : act_len;
  assign idle_eff = (idle_len == '0) ? CNT_W'(1) : idle_len;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // state_q is the per-channel FSM state, reachable hierarchically as g_ch[i].state_q.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_l_q, idle_l_q;
    logic             latch_len;
    logic             pass_d, pass_q;
    logic             abort_d, abort_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        act_l_q  <= '0;
        idle_l_q <= '0;
        pass_q   <= 1'b0;
        abort_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pass_q  <= pass_d;
        abort_q <= abort_d;
        if (latch_len) begin
          act_l_q  <= act_eff;
          idle_l_q <= idle_eff;
        end
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      latch_len = 1'b0;
      pass_d    = 1'b0;
      abort_d   = 1'b0;
      if (clr[i]) begin
        // Clear outranks every transition, including a same-edge entry to DONE.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (en && s[i]) begin
              state_d   = ST_ACTIVE;
              cnt_d     = CNT_W'(1);
              latch_len = 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (!en) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (s[i]) begin
              cnt_d = (cnt_q < act_l_q) ? cnt_q + CNT_W'(1) : act_l_q;
            end else if (cnt_q < act_l_q) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              abort_d = 1'b1;
            end else if (idle_l_q == CNT_W'(1)) begin
              state_d = ST_DONE;
              pass_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end
          ST_RELEASE: begin
            if (!en) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (s[i]) begin
              // A bounce back to active restarts qualification from scratch.
              state_d = ST_ACTIVE;
              cnt_d   = CNT_W'(1);
            end else if (({1'b0, cnt_q} + (CNT_W+1)'(1)) >= {1'b0, idle_l_q}) begin
              state_d = ST_DONE;
              pass_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          ST_DONE: begin
            state_d = ST_DONE;
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign passed[i]      = (state_q == ST_DONE);
    assign busy[i]        = (state_q == ST_ACTIVE) || (state_q == ST_RELEASE);
    assign pass_pulse[i]  = pass_q;
    assign abort_pulse[i] = abort_q;
  end

  assign any_passed = |passed;

endmodule

// File: tb/tb_sensor_dwell_qualifier.sv
// Directed bench for sensor_dwell_qualifier: a per-edge vector table for the nominal and
// short-active cases, then hand sequences for bounce, zero lengths, clear, reset and enable.
module tb_sensor_dwell_qualifier;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [CNT_W-1:0] act_len;
  logic [CNT_W-1:0] idle_len;
  logic [N_CH-1:0]  sens_active;
  logic [N_CH-1:0]  clr;
  logic [N_CH-1:0]  passed;
  logic [N_CH-1:0]  pass_pulse;
  logic [N_CH-1:0]  abort_pulse;
  logic [N_CH-1:0]  busy;
  logic             any_passed;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [3:0] sens;
    logic [3:0] clr;
    logic [3:0] e_passed;
    logic [3:0] e_pulse;
    logic [3:0] e_abort;
    logic [3:0] e_busy;
  } vec_t;

  vec_t tbl [10];

  sensor_dwell_qualifier #(.N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .act_len     (act_len),
    .idle_len    (idle_len),
    .sens_active (sens_active),
    .clr         (clr),
    .passed      (passed),
    .pass_pulse  (pass_pulse),
    .abort_pulse (abort_pulse),
    .busy        (busy),
    .any_passed  (any_passed)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ep, input logic [3:0] epu,
                           input logic [3:0] ea, input logic [3:0] eb);
    check({tag, ".passed"}, passed, ep);
    check({tag, ".pass_pulse"}, pass_pulse, epu);
    check({tag, ".abort_pulse"}, abort_pulse, ea);
    check({tag, ".busy"}, busy, eb);
    check({tag, ".any_passed"}, {3'b000, any_passed}, {3'b000, |ep});
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    en          = 1'b1;
    sens_active = '0;
    clr         = '0;
    act_len     = 16'd4;
    idle_len    = 16'd3;
    step();
    step();
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] e;
    logic        saw_pass;

    // ch0 high for 4 sampled edges, ch1 high for 3; act_len=4, idle_len=3.
    tbl[0] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[2] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
    tbl[3] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
    tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
    tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};

    do_reset();

    for (int k = 0; k < 10; k++)
      exp_q.push_back({tbl[k].e_passed, tbl[k].e_pulse, tbl[k].e_abort, tbl[k].e_busy});
    for (int k = 0; k < 10; k++) begin
      sens_active = tbl[k].sens;
      clr         = tbl[k].clr;
      step();
      e = exp_q.pop_front();
      check_all($sformatf("nominal_e%0d", k), e[15:12], e[11:8], e[7:4], e[3:0]);
    end

    // Sticky passed drops on clear.
    clr = 4'b0001;
    step();
    clr = 4'b0000;
    check_all("clr_sticky", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Release bounce on ch2: high 4, low 2, high 1, low 10.
    do_reset();
    saw_pass = 1'b0;
    for (int k = 0; k < 17; k++) begin
      sens_active = (k < 4 || k == 6) ? 4'b0100 : 4'b0000;
      step();
      saw_pass = saw_pass | passed[2] | pass_pulse[2];
      if (k == 7) check_all("bounce_release", 4'b0000, 4'b0000, 4'b0000, 4'b0100);
      if (k == 8) check_all("bounce_reactive", 4'b0000, 4'b0000, 4'b0000, 4'b0100);
      if (k == 9) check_all("bounce_abort", 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    end
    check("bounce_no_pass", {3'b000, saw_pass}, 4'b0000);
    for (int k = 0; k < 9; k++) begin
      sens_active = (k < 4) ? 4'b0100 : 4'b0000;
      step();
      if (k == 7) check_all("fresh_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    end
    check_all("fresh_pass", 4'b0100, 4'b0100, 4'b0000, 4'b0000);

    // Zero lengths act as 1; ch3 held high for 50 edges.
    do_reset();
    act_len  = 16'd0;
    idle_len = 16'd0;
    for (int k = 0; k < 54; k++) begin
      sens_active = (k < 50) ? 4'b1000 : 4'b0000;
      step();
      if (k == 49) check_all("zero_hold", 4'b0000, 4'b0000, 4'b0000, 4'b1000);
      if (k == 51) check_all("zero_last_hi", 4'b0000, 4'b0000, 4'b0000, 4'b1000);
      if (k == 52) check_all("zero_pass", 4'b1000, 4'b1000, 4'b0000, 4'b0000);
      if (k == 53) check_all("zero_after", 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    end

    // Clear on the same edge ch0 would enter DONE.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      sens_active = (k < 4) ? 4'b0001 : 4'b0000;
      clr         = (k == 8) ? 4'b0001 : 4'b0000;
      step();
      if (k == 7) check_all("clr_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      if (k == 8) check_all("clr_collide", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      if (k == 9) check_all("clr_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    // Reset while ch0 is in RELEASE.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      sens_active = (k < 4) ? 4'b0001 : 4'b0000;
      reset       = (k == 7) ? 1'b0 : 1'b1;
      step();
      if (k == 6) check_all("rst_release", 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      if (k == 7) check_all("rst_mid", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      if (k == 9) check_all("rst_discard", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    reset = 1'b1;

    // Lengths latched at dwell start; later changes ignored.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      sens_active = (k < 4) ? 4'b0001 : 4'b0000;
      if (k == 3) begin
        act_len  = 16'd100;
        idle_len = 16'd100;
      end
      step();
      if (k == 7) check_all("latch_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    end
    check_all("latch_pass", 4'b0001, 4'b0001, 4'b0000, 4'b0000);

    // Drop enable while ch1 is in RELEASE; ch0 stays DONE.
    act_len  = 16'd4;
    idle_len = 16'd3;
    for (int k = 0; k < 11; k++) begin
      sens_active = (k < 4) ? 4'b0010 : 4'b0000;
      en          = (k == 7) ? 1'b0 : 1'b1;
      step();
      if (k == 6) check_all("en_release", 4'b0001, 4'b0000, 4'b0000, 4'b0010);
      if (k == 7) check_all("en_drop", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      if (k == 10) check_all("en_after", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
